// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm scheduler
// Purpose: channel state enum, time-field widths and a small helper for
//          sizing the per-channel seconds counter.
// Ports:   none (package).
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_t;

   localparam int HOUR_W     = 5;
   localparam int MIN_W      = 6;
   localparam int SEC_W      = 6;
   localparam int TIME_W_DEF = HOUR_W + MIN_W + SEC_W;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter must hold values up to max(RING_SEC, SNOOZE_SEC)-1.
   function automatic int cnt_width(input int ring_sec, input int snooze_sec);
      int m;
      m = max_int(ring_sec, snooze_sec);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// rtl/alarm_scheduler_if.sv - bus between clock datapath and alarm scheduler
// Purpose: groups time/alarm configuration, user requests and the
//          ringing status outputs of the scheduler.
// Signals: SEC_TICK, CURRENT_TIME, ALARM_TIME, ALARM_ENABLE, STOP_REQ,
//          SNOOZE_REQ (to scheduler); ALARM_DOING, ALARM_ID, RINGING,
//          SNOOZED (from scheduler).
// Modports: master = clock/key side, slave = scheduler.
interface alarm_scheduler_if #(
   parameter int N_ALARMS = 4,
   parameter int TIME_W   = alarm_pkg::TIME_W_DEF
);
   localparam int IDW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

   logic                         SEC_TICK;
   logic [TIME_W-1:0]            CURRENT_TIME;
   logic [N_ALARMS*TIME_W-1:0]   ALARM_TIME;
   logic [N_ALARMS-1:0]          ALARM_ENABLE;
   logic                         STOP_REQ;
   logic                         SNOOZE_REQ;
   logic                         ALARM_DOING;
   logic [IDW-1:0]               ALARM_ID;
   logic [N_ALARMS-1:0]          RINGING;
   logic [N_ALARMS-1:0]          SNOOZED;

   modport master (
      output SEC_TICK, CURRENT_TIME, ALARM_TIME, ALARM_ENABLE, STOP_REQ, SNOOZE_REQ,
      input  ALARM_DOING, ALARM_ID, RINGING, SNOOZED
   );

   modport slave (
      input  SEC_TICK, CURRENT_TIME, ALARM_TIME, ALARM_ENABLE, STOP_REQ, SNOOZE_REQ,
      output ALARM_DOING, ALARM_ID, RINGING, SNOOZED
   );

endinterface

// File: rtl/alarm_channel.sv
// rtl/alarm_channel.sv - one alarm channel: edge detect, ring/snooze FSM, timer
// Purpose: fires on the rising edge of its match, rings for RING_SEC ticks,
//          snoozes for SNOOZE_SEC ticks, reacts to qualified stop/snooze.
// Ports:   CLK, RESETN (sync, active-low); match, enable, sec_tick,
//          stop, snooze (already qualified as "this channel is active");
//          ringing, snoozed status outputs decoded from the state register.
module alarm_channel
   import alarm_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int CNT_W      = 9
) (
   input  logic CLK,
   input  logic RESETN,
   input  logic match,
   input  logic enable,
   input  logic sec_tick,
   input  logic stop,
   input  logic snooze,
   output logic ringing,
   output logic snoozed
);

   localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
   localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);

   alarm_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic             match_q;

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state   <= IDLE;
         cnt     <= '0;
         match_q <= 1'b0;
      end else begin
         match_q <= match;
         if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (match && !match_q) begin
            // A new match re-arms the channel from any state; a tick in
            // this same cycle is deliberately not counted.
            state <= RINGING;
            cnt   <= '0;
         end else begin
            case (state)
               RINGING: begin
                  if (stop) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (snooze) begin
                     state <= SNOOZE;
                     cnt   <= '0;
                  end else if (sec_tick) begin
                     if (cnt == RING_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
               end
               SNOOZE: begin
                  if (sec_tick) begin
                     if (cnt == SNOOZE_LAST) begin
                        state <= RINGING;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign ringing = (state == RINGING);
   assign snoozed = (state == SNOOZE);

endmodule

// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - multi-channel alarm engine top level
// Purpose: compares CURRENT_TIME against N_ALARMS alarm times, runs one
//          alarm_channel per alarm, picks the lowest-index ringing channel
//          as the active one and routes STOP/SNOOZE requests only to it.
// Ports:   CLK, RESETN (sync, active-low); bus (alarm_scheduler_if.slave)
//          carrying time/config/request inputs and ALARM_DOING, ALARM_ID,
//          RINGING, SNOOZED outputs.
module alarm_scheduler
   import alarm_pkg::*;
#(
   parameter int N_ALARMS   = 4,
   parameter int TIME_W     = TIME_W_DEF,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300
) (
   input  logic              CLK,
   input  logic              RESETN,
   alarm_scheduler_if.slave  bus
);

   localparam int IDW   = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
   localparam int CNT_W = cnt_width(RING_SEC, SNOOZE_SEC);

   logic [N_ALARMS-1:0] match;
   logic [N_ALARMS-1:0] ringing;
   logic [N_ALARMS-1:0] snoozed;
   logic [N_ALARMS-1:0] active_oh;
   logic [IDW-1:0]      alarm_id;

   always_comb begin
      match = '0;
      for (int i = 0; i < N_ALARMS; i++) begin
         match[i] = bus.ALARM_ENABLE[i] &&
                    (bus.CURRENT_TIME == bus.ALARM_TIME[i*TIME_W +: TIME_W]);
      end
   end

   // Lowest-index priority encoder over the registered ringing flags, so
   // the active channel and ALARM_ID never depend combinationally on inputs.
   always_comb begin
      active_oh = '0;
      alarm_id  = '0;
      for (int i = N_ALARMS - 1; i >= 0; i--) begin
         if (ringing[i]) begin
            active_oh    = '0;
            active_oh[i] = 1'b1;
            alarm_id     = IDW'(i);
         end
      end
   end

   for (genvar g = 0; g < N_ALARMS; g++) begin : g_ch
      alarm_channel #(
         .RING_SEC   (RING_SEC),
         .SNOOZE_SEC (SNOOZE_SEC),
         .CNT_W      (CNT_W)
      ) u_ch (
         .CLK      (CLK),
         .RESETN   (RESETN),
         .match    (match[g]),
         .enable   (bus.ALARM_ENABLE[g]),
         .sec_tick (bus.SEC_TICK),
         .stop     (bus.STOP_REQ && active_oh[g]),
         .snooze   (bus.SNOOZE_REQ && active_oh[g]),
         .ringing  (ringing[g]),
         .snoozed  (snoozed[g])
      );
   end

   assign bus.RINGING     = ringing;
   assign bus.SNOOZED     = snoozed;
   assign bus.ALARM_DOING = |ringing;
   assign bus.ALARM_ID    = alarm_id;

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb/tb_alarm_scheduler.sv - self-checking bench for alarm_scheduler
module tb_alarm_scheduler;

   typedef struct {
      logic        rstn;
      logic        tick;
      logic [16:0] cur;
      logic [16:0] a1;
      logic [3:0]  en;
      logic        stop;
      logic        snz;
      logic [3:0]  ring;
      logic [3:0]  snzd;
      logic [1:0]  id;
      string       name;
   } vec_t;

   logic clk;
   logic resetn;

   alarm_scheduler_if #(.N_ALARMS(4), .TIME_W(17)) bus ();

   alarm_scheduler #(
      .N_ALARMS   (4),
      .TIME_W     (17),
      .RING_SEC   (3),
      .SNOOZE_SEC (5)
   ) dut (
      .CLK    (clk),
      .RESETN (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   function automatic logic [16:0] tm(input int h, input int m, input int s);
      logic [4:0] hh;
      logic [5:0] mm;
      logic [5:0] ss;
      hh = 5'(h);
      mm = 6'(m);
      ss = 6'(s);
      return {hh, mm, ss};
   endfunction

   function automatic vec_t mk(input logic rstn, input logic tick, input logic [16:0] cur,
                               input logic [3:0] en, input logic stop, input logic snz,
                               input logic [3:0] ring, input logic [3:0] snzd,
                               input logic [1:0] id, input string name);
      vec_t v;
      v.rstn = rstn; v.tick = tick; v.cur = cur; v.a1 = tm(7, 30, 0);
      v.en = en; v.stop = stop; v.snz = snz;
      v.ring = ring; v.snzd = snzd; v.id = id; v.name = name;
      return v;
   endfunction

   task automatic chk4(input string name, input string what, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %b expected %b", name, what, act, exp);
      end
   endtask

   // Drive one vector, queue its expectation, clock once, then compare.
   task automatic step(input vec_t v);
      vec_t e;
      resetn           = v.rstn;
      bus.SEC_TICK     = v.tick;
      bus.CURRENT_TIME = v.cur;
      bus.ALARM_TIME   = {tm(8, 0, 0), tm(6, 0, 0), v.a1, tm(6, 0, 0)};
      bus.ALARM_ENABLE = v.en;
      bus.STOP_REQ     = v.stop;
      bus.SNOOZE_REQ   = v.snz;
      exp_q.push_back(v);
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: queue empty, expected 1 entry");
      end else begin
         e = exp_q.pop_front();
         chk4(e.name, "RINGING", bus.RINGING, e.ring);
         chk4(e.name, "SNOOZED", bus.SNOOZED, e.snzd);
         chk4(e.name, "ALARM_ID", {2'b00, bus.ALARM_ID}, {2'b00, e.id});
         chk4(e.name, "ALARM_DOING", {3'b000, bus.ALARM_DOING}, {3'b000, |e.ring});
      end
   endtask

   initial begin
      vec_t v;
      resetn           = 1'b0;
      bus.SEC_TICK     = 1'b0;
      bus.CURRENT_TIME = '0;
      bus.ALARM_TIME   = '0;
      bus.ALARM_ENABLE = '0;
      bus.STOP_REQ     = 1'b0;
      bus.SNOOZE_REQ   = 1'b0;
      @(negedge clk);

      // basic fire, single trigger across equal-time window, auto-off
      tbl.push_back(mk(0, 0, tm(7, 29, 59), 4'hF, 0, 0, 4'b0000, 4'b0000, 0, "reset"));
      tbl.push_back(mk(1, 0, tm(7, 29, 59), 4'hF, 0, 0, 4'b0000, 4'b0000, 0, "idle"));
      tbl.push_back(mk(1, 1, tm(7, 30, 0),  4'hF, 0, 0, 4'b0010, 4'b0000, 1, "fire"));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1, 0, tm(7, 30, 0), 4'hF, 0, 0, 4'b0010, 4'b0000, 1, "hold"));
      tbl.push_back(mk(1, 1, tm(7, 30, 1), 4'hF, 0, 0, 4'b0010, 4'b0000, 1, "tick1"));
      tbl.push_back(mk(1, 0, tm(7, 30, 1), 4'hF, 0, 0, 4'b0010, 4'b0000, 1, "notick"));
      tbl.push_back(mk(1, 1, tm(7, 30, 2), 4'hF, 0, 0, 4'b0010, 4'b0000, 1, "tick2"));
      tbl.push_back(mk(1, 1, tm(7, 30, 3), 4'hF, 0, 0, 4'b0000, 4'b0000, 0, "autooff"));
      // stop priority
      tbl.push_back(mk(1, 0, tm(5, 59, 59), 4'hF, 0, 0, 4'b0000, 4'b0000, 0, "pre6"));
      tbl.push_back(mk(1, 1, tm(6, 0, 0),   4'hF, 0, 0, 4'b0101, 4'b0000, 0, "dual"));
      tbl.push_back(mk(1, 0, tm(6, 0, 0),   4'hF, 1, 0, 4'b0100, 4'b0000, 2, "stop1"));
      tbl.push_back(mk(1, 0, tm(6, 0, 0),   4'hF, 1, 0, 4'b0000, 4'b0000, 0, "stop2"));
      // snooze on ch3
      tbl.push_back(mk(1, 1, tm(8, 0, 0), 4'hF, 0, 0, 4'b1000, 4'b0000, 3, "ch3fire"));
      tbl.push_back(mk(1, 0, tm(8, 0, 0), 4'hF, 0, 1, 4'b0000, 4'b1000, 0, "snooze"));
      for (int i = 1; i <= 4; i++)
         tbl.push_back(mk(1, 1, tm(8, 0, i), 4'hF, 0, 0, 4'b0000, 4'b1000, 0, "snzwait"));
      tbl.push_back(mk(1, 1, tm(8, 0, 5), 4'hF, 0, 0, 4'b1000, 4'b0000, 3, "rering"));
      tbl.push_back(mk(1, 1, tm(8, 0, 6), 4'hF, 0, 0, 4'b1000, 4'b0000, 3, "rering1"));
      tbl.push_back(mk(1, 1, tm(8, 0, 7), 4'hF, 0, 0, 4'b1000, 4'b0000, 3, "rering2"));
      tbl.push_back(mk(1, 1, tm(8, 0, 8), 4'hF, 0, 0, 4'b0000, 4'b0000, 0, "reringoff"));
      // simultaneous stop+snooze, then cancel by disable
      tbl.push_back(mk(1, 1, tm(7, 59, 59), 4'hF, 0, 0, 4'b0000, 4'b0000, 0, "pre8"));
      tbl.push_back(mk(1, 1, tm(8, 0, 0),   4'hF, 0, 0, 4'b1000, 4'b0000, 3, "fire3b"));
      tbl.push_back(mk(1, 0, tm(8, 0, 0),   4'hF, 1, 1, 4'b0000, 4'b0000, 0, "stopwins"));
      tbl.push_back(mk(1, 1, tm(8, 0, 1),   4'hF, 0, 0, 4'b0000, 4'b0000, 0, "away"));
      tbl.push_back(mk(1, 0, tm(8, 0, 0),   4'hF, 0, 0, 4'b1000, 4'b0000, 3, "fire3c"));
      tbl.push_back(mk(1, 0, tm(8, 0, 0),   4'hF, 0, 1, 4'b0000, 4'b1000, 0, "snooze3c"));
      tbl.push_back(mk(1, 1, tm(8, 0, 1),   4'hF, 0, 0, 4'b0000, 4'b1000, 0, "snz3c"));
      tbl.push_back(mk(1, 0, tm(8, 0, 1),   4'h7, 0, 0, 4'b0000, 4'b0000, 0, "cancel"));
      for (int i = 2; i <= 6; i++)
         tbl.push_back(mk(1, 1, tm(8, 0, i), 4'hF, 0, 0, 4'b0000, 4'b0000, 0, "noring"));

      foreach (tbl[i]) step(tbl[i]);

      // retrigger during snooze by rewriting ch1 alarm time, then reset mid-ring
      step(mk(1, 1, tm(7, 30, 0), 4'hF, 0, 0, 4'b0010, 4'b0000, 1, "e_fire"));
      step(mk(1, 0, tm(7, 30, 0), 4'hF, 0, 1, 4'b0000, 4'b0010, 0, "e_snooze"));
      step(mk(1, 1, tm(7, 30, 1), 4'hF, 0, 0, 4'b0000, 4'b0010, 0, "e_snz1"));
      step(mk(1, 1, tm(7, 30, 2), 4'hF, 0, 0, 4'b0000, 4'b0010, 0, "e_snz2"));
      v = mk(1, 0, tm(7, 30, 2), 4'hF, 0, 0, 4'b0010, 4'b0000, 1, "retrig");
      v.a1 = tm(7, 30, 2);
      step(v);
      v = mk(1, 1, tm(7, 30, 3), 4'hF, 0, 0, 4'b0010, 4'b0000, 1, "retrig_t1");
      v.a1 = tm(7, 30, 2);
      step(v);
      v = mk(1, 1, tm(7, 30, 4), 4'hF, 0, 0, 4'b0010, 4'b0000, 1, "retrig_t2");
      v.a1 = tm(7, 30, 2);
      step(v);
      v = mk(1, 1, tm(7, 30, 5), 4'hF, 0, 0, 4'b0000, 4'b0000, 0, "retrig_off");
      v.a1 = tm(7, 30, 2);
      step(v);
      v = mk(1, 0, tm(7, 30, 2), 4'hF, 0, 0, 4'b0010, 4'b0000, 1, "ring_again");
      v.a1 = tm(7, 30, 2);
      step(v);
      v = mk(0, 0, tm(7, 30, 2), 4'hF, 0, 0, 4'b0000, 4'b0000, 0, "mid_reset");
      v.a1 = tm(7, 30, 2);
      step(v);
      v = mk(1, 0, tm(7, 30, 2), 4'hF, 0, 0, 4'b0010, 4'b0000, 1, "fire_after_rst");
      v.a1 = tm(7, 30, 2);
      step(v);

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Multi-channel alarm engine that replaces the single-alarm time comparator in the alarm-clock datapath. It compares the running clock time against `N_ALARMS` programmable alarm times and starts a channel on the first cycle of a match. Each channel has its own ring/snooze state machine with auto-off and snooze timers driven by the one-second tick. The block feeds the buzzer/LED driver through `ALARM_DOING` and the display through `ALARM_ID`, and takes user STOP/SNOOZE button pulses from the key debouncer.

## Interface
Parameters:
- `N_ALARMS`, 4: number of alarm channels, ≥1.
- `TIME_W`, 17: time word width; {hour[16:12], min[11:6], sec[5:0]}. The block treats it as opaque.
- `RING_SEC`, 60: seconds a channel rings before auto-off, ≥1.
- `SNOOZE_SEC`, 300: seconds a snoozed channel waits before re-ringing, ≥1.

Ports (reset `RESETN`, synchronous, active-low; clock `CLK`):
- `CLK` in 1: system clock.
- `RESETN` in 1: synchronous active-low reset.
- `SEC_TICK` in 1: one-cycle pulse per second, aligned to `CURRENT_TIME` updates.
- `CURRENT_TIME` in `TIME_W`: running clock time.
- `ALARM_TIME` in `N_ALARMS*TIME_W`: channel i at `[i*TIME_W +: TIME_W]`.
- `ALARM_ENABLE` in `N_ALARMS`: per-channel arm.
- `STOP_REQ` in 1: one-cycle pulse; stop the active channel.
- `SNOOZE_REQ` in 1: one-cycle pulse; snooze the active channel.
- `ALARM_DOING` out 1: any channel ringing.
- `ALARM_ID` out `IDW`: index of the active channel, where `IDW = max(1, $clog2(N_ALARMS))`.
- `RINGING` out `N_ALARMS`: per-channel ringing flags.
- `SNOOZED` out `N_ALARMS`: per-channel snoozed flags.

## Operation
- `match[i] = ALARM_ENABLE[i] && (CURRENT_TIME == ALARM_TIME[i])`. Register it into `match_q[i]`, which resets to 0.
- `trig[i] = match[i] && !match_q[i]`. A channel fires once per match occurrence, not for every cycle the match holds.
- The active channel is the lowest-index channel in RINGING. `STOP_REQ` and `SNOOZE_REQ` act only on the active channel; other ringing channels are unaffected. If no channel rings, both requests are ignored.
- Per-channel FSM with states IDLE, RINGING and SNOOZE, plus a seconds counter `cnt` of width `CNT_W = $clog2(max(RING_SEC, SNOOZE_SEC))` (minimum 1). Transition priority, highest first:
  1. `ALARM_ENABLE[i]` = 0: go to IDLE, `cnt` = 0. This applies from any state.
  2. `trig[i]`: go to RINGING, `cnt` = 0. This applies from any state, so it re-arms a channel that is ringing or snoozed.
  3. RINGING and active and `STOP_REQ`: go to IDLE. STOP wins over a simultaneous SNOOZE.
  4. RINGING and active and `SNOOZE_REQ`: go to SNOOZE, `cnt` = 0.
  5. RINGING and `SEC_TICK`:
     - If `cnt == RING_SEC-1`, go to IDLE (auto-off).
     - Otherwise `cnt` += 1.
  6. SNOOZE and `SEC_TICK`:
     - If `cnt == SNOOZE_SEC-1`, go to RINGING with `cnt` = 0.
     - Otherwise `cnt` += 1.
  7. In all other cases, hold state and `cnt`.
- Output decode:
  - `RINGING[i]` is high when the channel state is RINGING.
  - `SNOOZED[i]` is high when the channel state is SNOOZE.
  - `ALARM_DOING = |RINGING`.
  - `ALARM_ID` is the lowest set index of `RINGING`, or 0 when none is set.

## Timing
- Reset values:
  - All channels IDLE, `cnt` = 0, `match_q` = 0.
  - `ALARM_DOING` = 0, `ALARM_ID` = 0, `RINGING` = 0, `SNOOZED` = 0.
- Fire latency: if `CURRENT_TIME` first equals `ALARM_TIME[i]` before clock edge k, `RINGING[i]` is high after edge k. This is 1 cycle, identical to the predecessor.
- If an alarm equals `CURRENT_TIME` while reset is released, the channel fires on the first edge after release.
- `STOP_REQ`/`SNOOZE_REQ` sampled at edge k take effect after edge k. `ALARM_ID` may change in the same cycle to the next ringing channel.
- Ring duration:
  - The auto-off count is exactly `RING_SEC` `SEC_TICK` pulses after entry.
  - The tick in the entry cycle is not counted when `trig` coincides with it; rule 2 overrides rule 5.
- Snooze duration: exactly `SNOOZE_SEC` ticks after the SNOOZE entry edge.
- Deasserting `ALARM_ENABLE` while a channel is snoozed cancels the snooze.
- `ALARM_TIME`/`ALARM_ENABLE` may change at any cycle. Writing an alarm time equal to the current time fires the channel on the next edge.
- Reset asserted mid-ring or mid-snooze returns all state to the reset values on that edge.
- All outputs decode from registers only; there is no combinational path from inputs to outputs.

## Structure
- Package `alarm_pkg`:
  - State enum `alarm_state_t` {IDLE, RINGING, SNOOZE}.
  - Time field width constants HOUR_W=5, MIN_W=6, SEC_W=6.
  - Default `TIME_W` = 17.
- Sub-module `alarm_channel`, instantiated with a generate loop, one per channel.
  - Inputs: `match`, `enable`, `sec_tick`, `stop`, `snooze`, with `stop`/`snooze` pre-qualified by "is active".
  - Contents: `match_q`, the FSM and `cnt`.
  - Outputs: `ringing` and `snoozed`.
- Top level holds the match comparators, the lowest-index priority encoder and the request qualification.

## Test plan
Use `N_ALARMS`=4, `RING_SEC`=3, `SNOOZE_SEC`=5.
- Basic fire and auto-off:
  - Stimulus: ch1 enabled at 07:30:00; step the time to 07:30:00 with a tick.
  - Required: `RINGING`=4'b0010 and `ALARM_ID`=1 one cycle later; held across a 4-cycle equal-time window (single trigger); cleared after the 3rd subsequent tick.
- Stop priority:
  - Stimulus: ch0 and ch2 both match 06:00:00; pulse `STOP_REQ`.
  - Required: `ALARM_ID`=0 first; after the stop, `RINGING`=4'b0100 and `ALARM_ID`=2; a second `STOP_REQ` gives `ALARM_DOING`=0.
- Snooze:
  - Stimulus: ch3 rings; pulse `SNOOZE_REQ`.
  - Required: `SNOOZED[3]`=1 and `RINGING[3]`=0; after the 5th tick, `RINGING[3]`=1; 3 ticks later, IDLE.
- Simultaneous requests and cancel:
  - Stimulus: `STOP_REQ` and `SNOOZE_REQ` in the same cycle.
  - Required: the channel goes to IDLE, not SNOOZE.
  - Stimulus: deassert `ALARM_ENABLE[3]` mid-snooze.
  - Required: `SNOOZED[3]`=0 on the next cycle and no re-ring.
- Retrigger and reset:
  - Stimulus: during SNOOZE, change `ALARM_TIME[1]` to the current time.
  - Required: RINGING after 1 cycle with a full 3-tick ring.
  - Stimulus: assert `RESETN`=0 mid-ring for 1 cycle.
  - Required: all outputs 0 the next cycle.
